serial_frame_sequencer: RTL and testbench

SERIAL_FRAME_SEQUENCER -- requirements
Module: serial_frame_sequencer

---
 rtl/serial_frame_sequencer.sv | 156 +++++++++++++++
 tb/tb_serial_frame_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_sequencer.sv
// serial_frame_sequencer
//   Receives serial frames of the form
//   start(1) | length (LEN_W bits, MSB first) | length+1 data bits | even parity.
//   The data bits themselves are captured by an external shift register;
//   this block only sequences the frame and raises shEn during the data bits.
//
// Ports
//   CLK     in   rising-edge clock for all state
//   RST     in   synchronous active-high reset
//   serIn   in   serial line, sampled on every rising CLK edge
//   rdAck   in   consumer acknowledge of a completed frame (used in DONE only)
//   shEn    out  shift enable for the external data register (high in DATA)
//   Done    out  frame complete, held until rdAck
//   parErr  out  parity error of the last completed frame
//   frmLen  out  length field of the last completed frame
//   busy    out  high whenever the sequencer is not idle
module serial_frame_sequencer #(
  parameter int LEN_W = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             serIn,
  input  logic             rdAck,
  output logic             shEn,
  output logic             Done,
  output logic             parErr,
  output logic [LEN_W-1:0] frmLen,
  output logic             busy
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LEN  = 3'd1;
  localparam logic [2:0] DATA = 3'd2;
  localparam logic [2:0] PAR  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(LEN_W - 1);

  // One step of the even-parity accumulation.
  function automatic logic parityStep(input logic acc, input logic bitIn);
    return acc ^ bitIn;
  endfunction

  logic [2:0]       state_r;
  logic [2:0]       nextState_s;
  logic [LEN_W-1:0] lenShift_r;
  logic [LEN_W-1:0] cnt_r;
  logic             runXor_r;
  logic [LEN_W:0]   lenWide_s;
  logic [LEN_W-1:0] lenNext_s;

  // Length register after shifting in the current bit; on the last LEN cycle
  // this is the complete length field, used to load the data counter.
  assign lenWide_s = {lenShift_r, serIn};
  assign lenNext_s = lenWide_s[LEN_W-1:0];

  // Next-state decode; cnt_r counts down to zero in both LEN and DATA.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (serIn) begin
          nextState_s = LEN;
        end else begin
          nextState_s = IDLE;
        end
      end
      LEN: begin
        if (cnt_r == CNT_ZERO) begin
          nextState_s = DATA;
        end else begin
          nextState_s = LEN;
        end
      end
      DATA: begin
        if (cnt_r == CNT_ZERO) begin
          nextState_s = PAR;
        end else begin
          nextState_s = DATA;
        end
      end
      PAR: begin
        nextState_s = DONE;
      end
      DONE: begin
        if (rdAck) begin
          nextState_s = IDLE;
        end else begin
          nextState_s = DONE;
        end
      end
      default: begin
        nextState_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs. Outputs are decoded from the
  // next state so they are valid in the same cycle the state is entered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= IDLE;
      lenShift_r <= CNT_ZERO;
      cnt_r      <= CNT_ZERO;
      runXor_r   <= 1'b0;
      shEn       <= 1'b0;
      Done       <= 1'b0;
      busy       <= 1'b0;
      parErr     <= 1'b0;
      frmLen     <= CNT_ZERO;
    end else begin
      state_r <= nextState_s;
      shEn    <= (nextState_s == DATA);
      Done    <= (nextState_s == DONE);
      busy    <= (nextState_s != IDLE);
      case (state_r)
        IDLE: begin
          if (serIn) begin
            cnt_r      <= LEN_LAST;
            lenShift_r <= CNT_ZERO;
            runXor_r   <= 1'b0;
          end
        end
        LEN: begin
          lenShift_r <= lenNext_s;
          // Counter reloads with the length so DATA lasts length+1 cycles;
          // all-ones length counts down from max without wrapping.
          if (cnt_r == CNT_ZERO) begin
            cnt_r <= lenNext_s;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        DATA: begin
          runXor_r <= parityStep(runXor_r, serIn);
          if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        PAR: begin
          parErr <= parityStep(runXor_r, serIn);
          frmLen <= lenShift_r;
        end
        DONE: begin
          // serIn ignored until acknowledged
        end
        default: begin
          // unreachable encodings fall back to IDLE via nextState_s
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_sequencer.sv
module tb_serial_frame_sequencer;

  localparam int LEN_W = 3;

  logic             CLK;
  logic             RST;
  logic             serIn;
  logic             rdAck;
  logic             shEn;
  logic             Done;
  logic             parErr;
  logic [LEN_W-1:0] frmLen;
  logic             busy;

  int errors = 0;
  int checks = 0;

  serial_frame_sequencer #(.LEN_W(LEN_W)) dut (
    .CLK(CLK), .RST(RST), .serIn(serIn), .rdAck(rdAck),
    .shEn(shEn), .Done(Done), .parErr(parErr), .frmLen(frmLen), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Frame-level reference model: phase 0 = idle, 1 = collecting bits after
  // the start bit, 2 = frame complete waiting for ack.
  int   mPhase = 0;
  logic mBits[$];
  int   mFrm   = 0;
  logic mPe    = 1'b0;

  function automatic int curLen();
    int v = 0;
    for (int i = 0; i < LEN_W; i++) v = v * 2 + int'(mBits[i]);
    return v;
  endfunction

  task automatic modelEdge(input logic r, input logic s, input logic a);
    if (r) begin
      mPhase = 0; mBits.delete(); mFrm = 0; mPe = 1'b0;
    end else if (mPhase == 0) begin
      if (s) begin mPhase = 1; mBits.delete(); end
    end else if (mPhase == 1) begin
      mBits.push_back(s);
      if (mBits.size() >= LEN_W && mBits.size() == LEN_W + curLen() + 2) begin
        logic x = 1'b0;
        for (int i = LEN_W; i < mBits.size(); i++) x = x ^ mBits[i];
        mPe = x; mFrm = curLen(); mPhase = 2;
      end
    end else begin
      if (a) mPhase = 0;
    end
  endtask

  function automatic logic expShEn();
    if (mPhase == 1 && mBits.size() >= LEN_W)
      return (mBits.size() < LEN_W + curLen() + 1);
    return 1'b0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model, compare DUT to model.
  task automatic step(input logic r, input logic s, input logic a);
    RST = r; serIn = s; rdAck = a;
    @(posedge CLK);
    modelEdge(r, s, a);
    #1;
    chk("m_shEn",   int'(shEn),   int'(expShEn()));
    chk("m_Done",   int'(Done),   int'(mPhase == 2));
    chk("m_busy",   int'(busy),   int'(mPhase != 0));
    chk("m_parErr", int'(parErr), int'(mPe));
    chk("m_frmLen", int'(frmLen), mFrm);
  endtask

  // Send a complete frame; returns number of cycles shEn was high.
  task automatic sendFrame(input int len, input logic badPar, output int shCnt);
    logic [LEN_W-1:0] lv;
    logic x;
    logic d;
    lv = LEN_W'(len);
    x = 1'b0;
    shCnt = 0;
    step(1'b0, 1'b1, 1'b0);
    for (int i = LEN_W - 1; i >= 0; i--) begin
      step(1'b0, lv[i], 1'b0);
      if (shEn) shCnt++;
    end
    for (int i = 0; i <= len; i++) begin
      d = 1'($urandom_range(0, 1));
      x = x ^ d;
      step(1'b0, d, 1'b0);
      if (shEn) shCnt++;
    end
    step(1'b0, x ^ badPar, 1'b0);
    chk("frame_done", int'(Done), 1);
    chk("frame_perr", int'(parErr), int'(badPar));
    chk("frame_len", int'(frmLen), len);
  endtask

  typedef struct {
    logic r; logic s; logic a;
    logic sh; logic dn; logic by; logic pe; logic [LEN_W-1:0] fl;
  } vec_t;

  vec_t vec[24];
  int   nVec;
  int   shCnt;
  logic rr, ss, aa;

  initial begin
    RST = 1'b1; serIn = 1'b0; rdAck = 1'b0;
    // nominal frame: 1 | 010 | 110 | 0, then ack; then same with parity 1
    vec[0]  = '{1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,3'd0};
    vec[1]  = '{1'b0,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b0,3'd0};
    vec[2]  = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,3'd0};
    vec[3]  = '{1'b0,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b0,3'd0};
    vec[4]  = '{1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,3'd0};
    vec[5]  = '{1'b0,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b0,3'd0};
    vec[6]  = '{1'b0,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b0,3'd0};
    vec[7]  = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,3'd0};
    vec[8]  = '{1'b0,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0,3'd2};
    vec[9]  = '{1'b0,1'b1,1'b0, 1'b0,1'b1,1'b1,1'b0,3'd2};
    vec[10] = '{1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,3'd2};
    vec[11] = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,3'd2};
    vec[12] = '{1'b0,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b0,3'd2};
    vec[13] = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,3'd2};
    vec[14] = '{1'b0,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b0,3'd2};
    vec[15] = '{1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,3'd2};
    vec[16] = '{1'b0,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b0,3'd2};
    vec[17] = '{1'b0,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b0,3'd2};
    vec[18] = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,3'd2};
    vec[19] = '{1'b0,1'b1,1'b0, 1'b0,1'b1,1'b1,1'b1,3'd2};
    vec[20] = '{1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b1,3'd2};
    vec[21] = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,3'd2};
    nVec = 22;

    for (int i = 0; i < nVec; i++) begin
      step(vec[i].r, vec[i].s, vec[i].a);
      chk($sformatf("vec%0d_shEn", i),   int'(shEn),   int'(vec[i].sh));
      chk($sformatf("vec%0d_Done", i),   int'(Done),   int'(vec[i].dn));
      chk($sformatf("vec%0d_busy", i),   int'(busy),   int'(vec[i].by));
      chk($sformatf("vec%0d_parErr", i), int'(parErr), int'(vec[i].pe));
      chk($sformatf("vec%0d_frmLen", i), int'(frmLen), int'(vec[i].fl));
    end

    // length extremes
    sendFrame(0, 1'b0, shCnt);
    chk("len0_shcnt", shCnt, 1);
    step(1'b0, 1'b0, 1'b1);
    sendFrame(7, 1'b1, shCnt);
    chk("len7_shcnt", shCnt, 8);
    step(1'b0, 1'b0, 1'b1);
    sendFrame(7, 1'b0, shCnt);
    chk("len7b_shcnt", shCnt, 8);

    // hold in DONE with toggling serIn, then ack with serIn=1
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'(i % 2), 1'b0);
      chk("hold_done", int'(Done), 1);
      chk("hold_busy", int'(busy), 1);
    end
    step(1'b0, 1'b1, 1'b1);
    chk("ack_idle", int'(busy), 0);
    sendFrame(2, 1'b0, shCnt);
    chk("after_ack_shcnt", shCnt, 3);
    step(1'b0, 1'b0, 1'b1);

    // reset during the 2nd DATA cycle
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("mid_in_data", int'(shEn), 1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("rst_shEn", int'(shEn), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frmLen", int'(frmLen), 0);
    chk("rst_parErr", int'(parErr), 0);
    sendFrame(3, 1'b0, shCnt);
    chk("post_rst_shcnt", shCnt, 4);
    step(1'b0, 1'b0, 1'b1);

    // idle line
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("idle_busy", int'(busy), 0);
      chk("idle_shEn", int'(shEn), 0);
      chk("idle_Done", int'(Done), 0);
    end

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 99) == 0);
      ss = 1'($urandom_range(0, 1));
      aa = ($urandom_range(0, 3) == 0);
      step(rr, ss, aa);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
